// File: rtl/ctrl_pkt_pkg.sv
// ctrl_pkt_pkg: constants and FSM state type shared by the control-packet transmitter and the receiving wrapper
package ctrl_pkt_pkg;
    localparam logic [15:0] CTRL_MAGIC  = 16'hC0DE;
    localparam logic [15:0] INSTR_WRITE = 16'h0001;
    localparam logic [15:0] INSTR_READ  = 16'h0002;
    localparam int          HDR_WORDS   = 6;
    typedef enum logic [1:0] {IDLE, HDR, PAY, DONE} state_t;
endpackage

// File: rtl/axis_skid_buf2.sv
// axis_skid_buf2: 2-entry output register / skid buffer for an AXI-Stream master
// Ports: clk/rst_n (async active-low); i_valid/i_data push a word (caller guarantees room);
//        o_valid/o_data drive the stream, popped on o_valid && i_ready; o_count = occupancy 0..2.
module axis_skid_buf2 #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic [1:0]   o_count
);
    logic [W-1:0] r_d0, r_d1;
    logic [1:0]   r_cnt;
    logic         w_pop;

    assign w_pop   = (r_cnt != 2'd0) && i_ready;
    assign o_valid = r_cnt != 2'd0;
    assign o_data  = r_d0;
    assign o_count = r_cnt;

    // r_d0 is the presented beat; it only changes when empty or when popped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d0  <= '0;
            r_d1  <= '0;
            r_cnt <= 2'd0;
        end else begin
            if ((r_cnt == 2'd0 || (r_cnt == 2'd1 && w_pop)) && i_valid)
                r_d0 <= i_data;
            else if (r_cnt == 2'd2 && w_pop)
                r_d0 <= r_d1;
            if (i_valid && ((r_cnt == 2'd1 && !w_pop) || (r_cnt == 2'd2 && w_pop)))
                r_d1 <= i_data;
            r_cnt <= r_cnt + {1'b0, i_valid} - {1'b0, w_pop};
        end
    end
endmodule

// File: rtl/axis_cmd_packet_tx.sv
// axis_cmd_packet_tx: builds BRAM control packets (6-word header + WRITE payload) on an AXI-Stream master
// Ports: aclk/aresetn (async active-low); cmd_* command request with valid/ready;
//        m_axis_* stream master; src_rd_* banked source memory (1-cycle read latency);
//        tx_busy/tx_done packet status; cmd_error pulse on rejected command.
module axis_cmd_packet_tx
    import ctrl_pkt_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int BRAM_COUNT = 16,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [DATA_WIDTH-1:0]         cmd_instr,
    input  logic [DATA_WIDTH-1:0]         cmd_bram_start,
    input  logic [DATA_WIDTH-1:0]         cmd_bram_end,
    input  logic [ADDR_WIDTH-1:0]         cmd_addr_start,
    input  logic [DATA_WIDTH-1:0]         cmd_count,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          src_rd_en,
    output logic [$clog2(BRAM_COUNT)-1:0] src_rd_bank,
    output logic [ADDR_WIDTH-1:0]         src_rd_addr,
    input  logic [DATA_WIDTH-1:0]         src_rd_data,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic                          cmd_error
);
    localparam int BW = $clog2(BRAM_COUNT);

    state_t                r_state, w_next;
    logic [DATA_WIDTH-1:0] r_instr, r_bstart, r_bend, r_count, r_k;
    logic [ADDR_WIDTH-1:0] r_astart, r_addr;
    logic [BW-1:0]         r_bank;
    logic [2:0]            r_hdr_idx;
    logic                  r_rd_done, r_inflight, r_inf_last, r_err;

    logic                  w_accept, w_bad, w_write, w_pop, w_push_hdr, w_hdr_final, w_hdr_last;
    logic                  w_push, w_issue, w_rd_last, w_out_valid;
    logic [1:0]            w_cnt, w_occ;
    logic [DATA_WIDTH-1:0] w_hdr_word;
    logic [DATA_WIDTH:0]   w_in_data, w_out;

    assign w_accept = cmd_valid && cmd_ready;
    assign w_bad    = (cmd_count == '0) || (cmd_bram_end < cmd_bram_start) ||
                      (cmd_bram_end >= DATA_WIDTH'(BRAM_COUNT));
    assign w_write  = r_instr == DATA_WIDTH'(INSTR_WRITE);
    assign w_pop    = w_out_valid && m_axis_tready;
    // occupancy left after this cycle's pop, before any push
    assign w_occ    = w_cnt - {1'b0, w_pop};

    assign w_hdr_final = r_hdr_idx == 3'(HDR_WORDS - 1);
    assign w_push_hdr  = (r_state == HDR) && (r_hdr_idx < 3'(HDR_WORDS)) && (w_occ != 2'd2);
    assign w_hdr_last  = w_hdr_final && !w_write;
    assign w_hdr_word  = (r_hdr_idx == 3'd0) ? DATA_WIDTH'(CTRL_MAGIC) :
                         (r_hdr_idx == 3'd1) ? r_instr  :
                         (r_hdr_idx == 3'd2) ? r_bstart :
                         (r_hdr_idx == 3'd3) ? r_bend   :
                         (r_hdr_idx == 3'd4) ? DATA_WIDTH'(r_astart) : r_count;

    // read data returning this cycle always has priority; header pushes never overlap it
    assign w_push    = w_push_hdr || r_inflight;
    assign w_in_data = r_inflight ? {r_inf_last, src_rd_data} : {w_hdr_last, w_hdr_word};

    // a read may only be issued if its word is guaranteed a buffer slot next cycle;
    // the first read goes out alongside the final header word so the stream stays gap-free
    assign w_rd_last = (r_bank == r_bend[BW-1:0]) && (r_k == r_count - 1'b1);
    assign w_issue   = w_write && !r_rd_done &&
                       (({1'b0, w_occ} + {2'b0, w_push}) < 3'd2) &&
                       ((w_push_hdr && w_hdr_final) || r_state == PAY);

    axis_skid_buf2 #(.W(DATA_WIDTH + 1)) u_skid (
        .clk     (aclk),
        .rst_n   (aresetn),
        .i_valid (w_push),
        .i_data  (w_in_data),
        .i_ready (m_axis_tready),
        .o_valid (w_out_valid),
        .o_data  (w_out),
        .o_count (w_cnt)
    );

    assign m_axis_tvalid = w_out_valid;
    assign m_axis_tdata  = w_out[DATA_WIDTH-1:0];
    assign m_axis_tlast  = w_out[DATA_WIDTH];
    assign cmd_ready     = r_state == IDLE;
    assign tx_busy       = (r_state == HDR) || (r_state == PAY);
    assign tx_done       = r_state == DONE;
    assign cmd_error     = r_err;
    assign src_rd_en     = w_issue;
    assign src_rd_bank   = r_bank;
    assign src_rd_addr   = r_addr;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE)
            w_next = (w_accept && !w_bad) ? HDR : IDLE;
        else if (r_state == DONE)
            w_next = IDLE;
        else if (w_pop && m_axis_tlast)
            w_next = DONE;
        else if (r_state == HDR && w_push_hdr && w_hdr_final && w_write)
            w_next = PAY;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_instr    <= '0;
            r_bstart   <= '0;
            r_bend     <= '0;
            r_count    <= '0;
            r_astart   <= '0;
            r_hdr_idx  <= '0;
            r_bank     <= '0;
            r_addr     <= '0;
            r_k        <= '0;
            r_rd_done  <= 1'b0;
            r_inflight <= 1'b0;
            r_inf_last <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err      <= w_accept && w_bad;
            r_inflight <= w_issue;
            r_inf_last <= w_rd_last;
            if (w_accept) begin
                r_instr   <= cmd_instr;
                r_bstart  <= cmd_bram_start;
                r_bend    <= cmd_bram_end;
                r_count   <= cmd_count;
                r_astart  <= cmd_addr_start;
                r_hdr_idx <= '0;
                r_bank    <= cmd_bram_start[BW-1:0];
                r_addr    <= cmd_addr_start;
                r_k       <= '0;
                r_rd_done <= 1'b0;
            end
            if (w_push_hdr)
                r_hdr_idx <= r_hdr_idx + 3'd1;
            // address wraps inside a bank; only exhausting count advances the bank
            if (w_issue) begin
                if (r_k == r_count - 1'b1) begin
                    r_k       <= '0;
                    r_bank    <= r_bank + 1'b1;
                    r_addr    <= r_astart;
                    r_rd_done <= w_rd_last;
                end else begin
                    r_k    <= r_k + 1'b1;
                    r_addr <= r_addr + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_axis_cmd_packet_tx.sv
// tb_axis_cmd_packet_tx: scoreboard bench for the command packet transmitter
module tb_axis_cmd_packet_tx;
    localparam int DW = 16, BC = 16, AW = 9, BW = 4;

    logic          aclk = 1'b0, aresetn = 1'b0;
    logic          cmd_valid = 1'b0, cmd_ready;
    logic [DW-1:0] cmd_instr = '0, cmd_bram_start = '0, cmd_bram_end = '0, cmd_count = '0;
    logic [AW-1:0] cmd_addr_start = '0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tlast, m_axis_tready = 1'b1;
    logic          src_rd_en;
    logic [BW-1:0] src_rd_bank;
    logic [AW-1:0] src_rd_addr;
    logic [DW-1:0] src_rd_data;
    logic          tx_busy, tx_done, cmd_error;

    always #5 aclk = ~aclk;

    axis_cmd_packet_tx dut (
        .aclk(aclk), .aresetn(aresetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_instr(cmd_instr), .cmd_bram_start(cmd_bram_start), .cmd_bram_end(cmd_bram_end),
        .cmd_addr_start(cmd_addr_start), .cmd_count(cmd_count),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .src_rd_en(src_rd_en), .src_rd_bank(src_rd_bank),
        .src_rd_addr(src_rd_addr), .src_rd_data(src_rd_data), .tx_busy(tx_busy),
        .tx_done(tx_done), .cmd_error(cmd_error)
    );

    int n_chk = 0, n_err = 0;
    int cyc = 0, beats = 0, t_first = 0, t_last = 0, done_cnt = 0, err_cnt = 0, rd_cnt = 0;
    bit rnd = 0, stall_prev = 0, err_prev = 0;
    logic [DW:0] prev_beat;
    logic [DW:0] exp_q[$];
    logic [BW+AW-1:0] rd_q[$];
    logic [DW-1:0] mem [BC][2**AW];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_init(input int b, input int a);
        return (b == 0) ? DW'(a + 1) : (b == 1) ? DW'(16'h0101 + a) : DW'((b << 12) | a);
    endfunction

    initial
        for (int b = 0; b < BC; b++)
            for (int a = 0; a < 2**AW; a++)
                mem[b][a] = mem_init(b, a);

    always @(posedge aclk)
        if (src_rd_en) src_rd_data <= mem[src_rd_bank][src_rd_addr];

    initial forever begin
        @(posedge aclk);
        #1 m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge aclk) begin
        logic [DW:0] e;
        cyc++;
        if (aresetn) begin
            if (stall_prev) chk("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, prev_beat});
            stall_prev = m_axis_tvalid && !m_axis_tready;
            prev_beat  = {m_axis_tlast, m_axis_tdata};
            if (m_axis_tvalid && m_axis_tready) begin
                beats++;
                if (beats == 1) t_first = cyc;
                t_last = cyc;
                if (exp_q.size() == 0) chk("unexpected_beat", exp_q.size(), 1);
                else begin
                    e = exp_q.pop_front();
                    chk("beat", {m_axis_tlast, m_axis_tdata}, e);
                end
            end
            if (tx_done) begin
                done_cnt++;
                chk("busy_at_done", tx_busy, 0);
            end
            if (cmd_error) begin
                err_cnt++;
                chk("err_pulse_width", err_prev, 0);
            end
            err_prev = cmd_error;
            if (src_rd_en) begin
                rd_cnt++;
                rd_q.push_back({src_rd_bank, src_rd_addr});
            end
        end else begin
            stall_prev = 0;
            err_prev   = 0;
        end
    end

    task automatic push_pkt(input logic [DW-1:0] ins, bs, be, input logic [AW-1:0] as, input logic [DW-1:0] cnt);
        bit wr = ins == 16'h0001;
        exp_q.push_back({1'b0, 16'hC0DE});
        exp_q.push_back({1'b0, ins});
        exp_q.push_back({1'b0, bs});
        exp_q.push_back({1'b0, be});
        exp_q.push_back({1'b0, DW'(as)});
        exp_q.push_back({!wr, cnt});
        if (wr)
            for (int b = int'(bs); b <= int'(be); b++)
                for (int k = 0; k < int'(cnt); k++)
                    exp_q.push_back({(b == int'(be)) && (k == int'(cnt) - 1),
                                     mem[b][(int'(as) + k) % (2**AW)]});
    endtask

    task automatic send_cmd(input logic [DW-1:0] ins, bs, be, input logic [AW-1:0] as, input logic [DW-1:0] cnt);
        int t = 0;
        while (!cmd_ready && t < 200) begin
            @(posedge aclk);
            t++;
        end
        chk("cmd_ready_wait", cmd_ready, 1);
        @(posedge aclk);
        #1;
        cmd_valid = 1'b1; cmd_instr = ins; cmd_bram_start = bs; cmd_bram_end = be;
        cmd_addr_start = as; cmd_count = cnt;
        @(posedge aclk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0, d0 = done_cnt;
        while (done_cnt == d0 && t < 3000) begin
            @(posedge aclk);
            t++;
        end
        chk("done_seen", done_cnt > d0, 1);
        repeat (3) @(posedge aclk);
        chk("done_once", done_cnt - d0, 1);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int d0, e0, b0, t;
        repeat (3) @(negedge aclk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_outs", {tx_busy, tx_done, cmd_error, src_rd_en, m_axis_tlast}, 0);
        @(posedge aclk);
        #1 aresetn = 1'b1;

        beats = 0;
        push_pkt(16'h0001, 0, 1, 0, 16);
        send_cmd(16'h0001, 0, 1, 0, 16);
        wait_done();
        chk("wr_beats", beats, 38);
        chk("wr_gap_free", t_last - t_first, 37);

        beats = 0; rd_cnt = 0;
        push_pkt(16'h0002, 0, 1, 0, 16);
        send_cmd(16'h0002, 0, 1, 0, 16);
        wait_done();
        chk("rd_beats", beats, 6);
        chk("rd_no_src_reads", rd_cnt, 0);

        rnd = 1; beats = 0;
        push_pkt(16'h0001, 0, 1, 0, 16);
        send_cmd(16'h0001, 0, 1, 0, 16);
        wait_done();
        chk("rnd_beats", beats, 38);
        rnd = 0;

        for (int i = 0; i < 3; i++) begin
            e0 = err_cnt; b0 = beats;
            if (i == 0) send_cmd(16'h0001, 3, 1, 0, 16);
            else if (i == 1) send_cmd(16'h0001, 0, 1, 0, 0);
            else send_cmd(16'h0002, 0, 16, 0, 4);
            repeat (4) @(negedge aclk);
            chk("inv_err_count", err_cnt - e0, 1);
            chk("inv_no_beats", beats - b0, 0);
            chk("inv_tvalid", m_axis_tvalid, 0);
            chk("inv_cmd_ready", cmd_ready, 1);
        end

        beats = 0; rd_q.delete();
        push_pkt(16'h0001, 2, 2, 9'h1F8, 16);
        send_cmd(16'h0001, 2, 2, 9'h1F8, 16);
        wait_done();
        chk("wrap_beats", beats, 22);
        chk("wrap_reads", rd_q.size(), 16);
        for (int i = 0; i < rd_q.size(); i++)
            chk("wrap_bank_addr", rd_q[i], {4'd2, 9'(9'h1F8 + i)});

        beats = 0; d0 = done_cnt; t = 0;
        push_pkt(16'h0001, 0, 1, 0, 16);
        send_cmd(16'h0001, 0, 1, 0, 16);
        while (beats < 20 && t < 500) begin
            @(negedge aclk);
            t++;
        end
        chk("pre_reset_beats", beats, 20);
        @(posedge aclk);
        #2;
        chk("pre_reset_tvalid", m_axis_tvalid, 1);
        aresetn = 1'b0;
        #1;
        chk("reset_trunc_tvalid", m_axis_tvalid, 0);
        chk("reset_busy", tx_busy, 0);
        chk("reset_cmd_ready", cmd_ready, 1);
        exp_q.delete();
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
        chk("reset_no_done", done_cnt - d0, 0);
        beats = 0;
        push_pkt(16'h0002, 0, 1, 0, 16);
        send_cmd(16'h0002, 0, 1, 0, 16);
        wait_done();
        chk("post_reset_beats", beats, 6);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
